// File: rtl/accel_txn_scheduler.sv
// accel_txn_scheduler: sequences all SPI traffic to the accelerometer.
// One configuration pass (T0 soft reset, T1 filter/range, T2 measurement mode)
// runs after enable rises. Periodic 5-byte sample reads follow, and each read
// publishes X/Y/Z as one coherent set. Chip select is owned here. The byte
// engine is fed over a valid/ready handshake.
// Optional build macro ACCEL_ID_CHECK_EN: reads the device ID before T0 and
// parks in ERR (id_err=1) on a mismatch.
//
// state      | meaning
// IDLE       | waiting for enable, cs high
// ID_XFER    | reading device ID (ACCEL_ID_CHECK_EN only)
// ERR        | ID mismatch, cs high until enable drops (ACCEL_ID_CHECK_EN only)
// INIT_XFER  | sending configuration transaction T0/T1/T2
// GAP        | cs held high for CS_GAP cycles after any transaction
// RST_WAIT   | device settling time after the soft-reset transaction
// POLL_WAIT  | interval between sample reads
// POLL_XFER  | reading X/Y/Z sample registers
module accel_txn_scheduler #(
    parameter int CS_GAP     = 4,
    parameter int RESET_WAIT = 50000,
    parameter int POLL_DIV   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       cs,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    input  logic       byte_ready,
    input  logic [7:0] byte_in,
    output logic       init_done,
    output logic [7:0] sample_x,
    output logic [7:0] sample_y,
    output logic [7:0] sample_z,
    output logic       sample_valid,
    output logic       id_err
);

    localparam int CNT_MAX_A = (CS_GAP > RESET_WAIT) ? CS_GAP : RESET_WAIT;
    localparam int CNT_MAX   = (CNT_MAX_A > POLL_DIV) ? CNT_MAX_A : POLL_DIV;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    localparam logic [2:0] TX_T0   = 3'd0;
    localparam logic [2:0] TX_T1   = 3'd1;
    localparam logic [2:0] TX_T2   = 3'd2;
    localparam logic [2:0] TX_POLL = 3'd3;
`ifdef ACCEL_ID_CHECK_EN
    localparam logic [2:0] TX_ID     = 3'd4;
    localparam logic [2:0] FIRST_TXN = TX_ID;
    localparam logic [7:0] DEV_ID    = 8'hAD;
`else
    localparam logic [2:0] FIRST_TXN = TX_T0;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
`ifdef ACCEL_ID_CHECK_EN
        ID_XFER   = 3'd1,
        ERR       = 3'd2,
`endif
        INIT_XFER = 3'd3,
        GAP       = 3'd4,
        RST_WAIT  = 3'd5,
        POLL_WAIT = 3'd6,
        POLL_XFER = 3'd7
    } state_t;

    // Transaction ROM: byte i of transaction t.
    function automatic logic [7:0] txn_byte(input logic [2:0] t, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (t)
            TX_T0:   b = (i == 3'd0) ? 8'h0A : (i == 3'd1) ? 8'h1F : (i == 3'd2) ? 8'h52 : 8'h00;
            TX_T1:   b = (i == 3'd0) ? 8'h0A : (i == 3'd1) ? 8'h2C : (i == 3'd2) ? 8'h13 : 8'h00;
            TX_T2:   b = (i == 3'd0) ? 8'h0A : (i == 3'd1) ? 8'h2D : (i == 3'd2) ? 8'h02 : 8'h00;
            TX_POLL: b = (i == 3'd0) ? 8'h0B : (i == 3'd1) ? 8'h08 : 8'h00;
`ifdef ACCEL_ID_CHECK_EN
            TX_ID:   b = (i == 3'd0) ? 8'h0B : 8'h00;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input logic [2:0] t);
        return (t == TX_POLL) ? 3'd4 : 3'd2;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       txn_q, txn_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_q, cs_d;
    logic             bv_q, bv_d;
    logic [7:0]       bo_q, bo_d;
    logic             init_done_q, init_done_d;
    logic             stop_q, stop_d;
    logic [7:0]       shx_q, shx_d, shy_q, shy_d;
    logic [7:0]       sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic             sv_q, sv_d;
    logic             start;
    logic [2:0]       start_txn;
`ifdef ACCEL_ID_CHECK_EN
    logic             id_err_q, id_err_d;
`endif

    // Next-state and next-output logic; every register has a held default.
    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        bv_d        = bv_q;
        bo_d        = bo_q;
        init_done_d = init_done_q;
        stop_d      = stop_q;
        shx_d       = shx_q;
        shy_d       = shy_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        sz_d        = sz_q;
        sv_d        = 1'b0;
        start       = 1'b0;
        start_txn   = TX_T0;
`ifdef ACCEL_ID_CHECK_EN
        id_err_d    = id_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    start_txn = FIRST_TXN;
                end
            end
`ifdef ACCEL_ID_CHECK_EN
            ID_XFER,
`endif
            INIT_XFER, POLL_XFER: begin
                // A transaction in flight always completes; enable low is remembered.
                if (!enable) stop_d = 1'b1;
                if (byte_ready && bv_q) begin
                    if (txn_q == TX_POLL) begin
                        case (idx_q)
                            3'd2: shx_d = byte_in;
                            3'd3: shy_d = byte_in;
                            3'd4: begin
                                sx_d = shx_q;
                                sy_d = shy_q;
                                sz_d = byte_in;
                                sv_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (idx_q == last_idx(txn_q)) begin
                        cs_d    = 1'b1;
                        bv_d    = 1'b0;
                        state_d = GAP;
                        cnt_d   = CNT_W'(CS_GAP - 1);
`ifdef ACCEL_ID_CHECK_EN
                        if (txn_q == TX_ID && byte_in != DEV_ID) begin
                            state_d  = ERR;
                            id_err_d = 1'b1;
                        end
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        bo_d  = txn_byte(txn_q, idx_q + 3'd1);
                    end
                end
            end
            GAP: begin
                if (!enable || stop_q) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    case (txn_q)
                        TX_T0: begin
                            state_d = RST_WAIT;
                            cnt_d   = CNT_W'(RESET_WAIT - 1);
                        end
                        TX_T1: begin
                            start     = 1'b1;
                            start_txn = TX_T2;
                        end
`ifdef ACCEL_ID_CHECK_EN
                        TX_ID: begin
                            start     = 1'b1;
                            start_txn = TX_T0;
                        end
`endif
                        default: begin
                            init_done_d = 1'b1;
                            state_d     = POLL_WAIT;
                            cnt_d       = CNT_W'(POLL_DIV - 1);
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RST_WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    start     = 1'b1;
                    start_txn = TX_T1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            POLL_WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    start     = 1'b1;
                    start_txn = TX_POLL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef ACCEL_ID_CHECK_EN
            ERR: begin
                if (!enable) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (start) begin
            txn_d = start_txn;
            idx_d = 3'd0;
            cs_d  = 1'b0;
            bv_d  = 1'b1;
            bo_d  = txn_byte(start_txn, 3'd0);
            if (start_txn == TX_POLL) state_d = POLL_XFER;
`ifdef ACCEL_ID_CHECK_EN
            else if (start_txn == TX_ID) state_d = ID_XFER;
`endif
            else state_d = INIT_XFER;
        end

        // Entering IDLE drops the configured status; samples are kept.
        if (state_d == IDLE) begin
            init_done_d = 1'b0;
            stop_d      = 1'b0;
            cnt_d       = '0;
`ifdef ACCEL_ID_CHECK_EN
            id_err_d    = 1'b0;
`endif
        end
    end

    // State and output registers; reset forces cs high at once, aborting any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            txn_q       <= TX_T0;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            cs_q        <= 1'b1;
            bv_q        <= 1'b0;
            bo_q        <= 8'h00;
            init_done_q <= 1'b0;
            stop_q      <= 1'b0;
            shx_q       <= 8'h00;
            shy_q       <= 8'h00;
            sx_q        <= 8'h00;
            sy_q        <= 8'h00;
            sz_q        <= 8'h00;
            sv_q        <= 1'b0;
`ifdef ACCEL_ID_CHECK_EN
            id_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            bv_q        <= bv_d;
            bo_q        <= bo_d;
            init_done_q <= init_done_d;
            stop_q      <= stop_d;
            shx_q       <= shx_d;
            shy_q       <= shy_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sz_q        <= sz_d;
            sv_q        <= sv_d;
`ifdef ACCEL_ID_CHECK_EN
            id_err_q    <= id_err_d;
`endif
        end
    end

    assign cs           = cs_q;
    assign byte_valid   = bv_q;
    assign byte_out     = bo_q;
    assign init_done    = init_done_q;
    assign sample_x     = sx_q;
    assign sample_y     = sy_q;
    assign sample_z     = sz_q;
    assign sample_valid = sv_q;
`ifdef ACCEL_ID_CHECK_EN
    assign id_err       = id_err_q;
`else
    assign id_err       = 1'b0;
`endif

endmodule

// File: tb/tb_accel_txn_scheduler.sv
// Directed bench for accel_txn_scheduler with a behavioural byte engine.
module tb_accel_txn_scheduler;

    localparam int CS_GAP     = 4;
    localparam int RESET_WAIT = 20;
    localparam int POLL_DIV   = 30;
    localparam int ACK_DLY    = 8;
    localparam int WAIT_LIM   = 300;

    localparam logic [39:0] T0_B   = 40'h0A1F520000;
    localparam logic [39:0] T1_B   = 40'h0A2C130000;
    localparam logic [39:0] T2_B   = 40'h0A2D020000;
    localparam logic [39:0] POLL_B = 40'h0B08000000;
    localparam logic [39:0] RSP0   = 40'h0000000000;
    localparam logic [39:0] RSP1   = 40'h0000123456;
    localparam logic [39:0] RSP2   = 40'h0000A1B2C3;
`ifdef ACCEL_ID_CHECK_EN
    localparam logic [39:0] ID_B   = 40'h0B00000000;
    localparam logic [39:0] ID_OK  = 40'h0000AD0000;
    localparam logic [39:0] ID_BAD = 40'h0000E50000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cs;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic [7:0] byte_in;
    logic       init_done;
    logic [7:0] sample_x, sample_y, sample_z;
    logic       sample_valid;
    logic       id_err;

    int checks = 0;
    int errors = 0;

    accel_txn_scheduler #(
        .CS_GAP(CS_GAP), .RESET_WAIT(RESET_WAIT), .POLL_DIV(POLL_DIV)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cs(cs),
        .byte_valid(byte_valid), .byte_out(byte_out),
        .byte_ready(byte_ready), .byte_in(byte_in),
        .init_done(init_done), .sample_x(sample_x), .sample_y(sample_y),
        .sample_z(sample_z), .sample_valid(sample_valid), .id_err(id_err)
    );

    always #5 clk = ~clk;

    // Engine model: for bytes first..last, wait for byte_valid, check the byte,
    // then acknowledge ACK_DLY cycles after it was presented. Returns on the
    // negedge right after the acknowledging posedge.
    task automatic serve_bytes(input int first, input int last, input logic [39:0] exp,
                               input logic [39:0] rsp, input string nm);
        for (int i = first; i <= last; i++) begin
            int t = 0;
            logic [7:0] eb;
            eb = exp[39-8*i -: 8];
            while (byte_valid !== 1'b1 && t < WAIT_LIM) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (byte_valid !== 1'b1 || cs !== 1'b0 || byte_out !== eb) begin
                errors++;
                $display("FAIL %s byte%0d: got valid=%b cs=%b byte=%h want valid=1 cs=0 byte=%h",
                         nm, i, byte_valid, cs, byte_out, eb);
            end
            repeat (ACK_DLY - 1) @(negedge clk);
            byte_in    = rsp[39-8*i -: 8];
            byte_ready = 1'b1;
            @(negedge clk);
            byte_ready = 1'b0;
            byte_in    = 8'h00;
        end
    endtask

    // Counts negedges with cs high starting from now (plus init); optionally
    // hammers byte_ready the whole time and flags any byte_out movement.
    task automatic measure_cs_high(input int init, input bit spur, output int n,
                                   output bit bo_changed);
        logic [7:0] bo0;
        bo0        = byte_out;
        n          = init;
        bo_changed = 1'b0;
        while (cs === 1'b1 && n < WAIT_LIM + POLL_DIV) begin
            if (byte_out !== bo0) bo_changed = 1'b1;
            byte_ready = spur;
            byte_in    = spur ? 8'hFF : 8'h00;
            n++;
            @(negedge clk);
        end
        byte_ready = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic serve_start(input string nm);
`ifdef ACCEL_ID_CHECK_EN
        int n;
        bit ch;
        serve_bytes(0, 2, ID_B, ID_OK, {nm, "_id"});
        measure_cs_high(0, 1'b0, n, ch);
        checks++;
        if (n !== CS_GAP) begin
            errors++;
            $display("FAIL %s_id_gap: got %0d want %0d", nm, n, CS_GAP);
        end
`endif
        serve_bytes(0, 2, T0_B, RSP0, {nm, "_t0"});
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; byte_ready = 1'b0; byte_in = 8'h00;
        #1;
        checks++;
        if (cs !== 1'b1 || byte_valid !== 1'b0 || byte_out !== 8'h00 || init_done !== 1'b0 ||
            {sample_x, sample_y, sample_z} !== 24'h000000 || sample_valid !== 1'b0 || id_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got cs=%b bv=%b bo=%h id=%b s=%h%h%h sv=%b ie=%b want 1 0 00 0 000000 0 0",
                     cs, byte_valid, byte_out, init_done, sample_x, sample_y, sample_z, sample_valid, id_err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (cs !== 1'b1 || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_enable: got cs=%b bv=%b want cs=1 bv=0", cs, byte_valid);
        end
    endtask

    task automatic test_init();
        int n;
        bit ch;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (cs !== 1'b0 || byte_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_to_xfer_latency: got cs=%b bv=%b want cs=0 bv=1", cs, byte_valid);
        end
        serve_start("init");
        measure_cs_high(0, 1'b0, n, ch);
        checks++;
        if (n !== CS_GAP + RESET_WAIT) begin
            errors++;
            $display("FAIL gap_t0_rst_wait: got %0d want %0d", n, CS_GAP + RESET_WAIT);
        end
        serve_bytes(0, 2, T1_B, RSP0, "init_t1");
        measure_cs_high(0, 1'b0, n, ch);
        checks++;
        if (n !== CS_GAP) begin
            errors++;
            $display("FAIL gap_t1_t2: got %0d want %0d", n, CS_GAP);
        end
        serve_bytes(0, 2, T2_B, RSP0, "init_t2");
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_done_early: got %b want 0", init_done);
        end
        measure_cs_high(0, 1'b0, n, ch);
        checks++;
        if (n !== CS_GAP + POLL_DIV) begin
            errors++;
            $display("FAIL gap_t2_poll: got %0d want %0d", n, CS_GAP + POLL_DIV);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done_set: got %b want 1", init_done);
        end
    endtask

    task automatic test_poll();
        int n;
        bit ch;
        serve_bytes(0, 3, POLL_B, RSP1, "poll1");
        checks++;
        if ({sample_x, sample_y, sample_z} !== 24'h000000 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL poll_before_last: got %h%h%h sv=%b want 000000 sv=0",
                     sample_x, sample_y, sample_z, sample_valid);
        end
        serve_bytes(4, 4, POLL_B, RSP1, "poll1");
        checks++;
        if ({sample_x, sample_y, sample_z} !== 24'h123456 || sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL poll1_capture: got %h%h%h sv=%b want 123456 sv=1",
                     sample_x, sample_y, sample_z, sample_valid);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL sample_valid_width: got %b want 0", sample_valid);
        end
        measure_cs_high(1, 1'b0, n, ch);
        checks++;
        if (n !== CS_GAP + POLL_DIV) begin
            errors++;
            $display("FAIL poll_repeat_gap: got %0d want %0d", n, CS_GAP + POLL_DIV);
        end
        serve_bytes(0, 4, POLL_B, RSP2, "poll2");
        checks++;
        if ({sample_x, sample_y, sample_z} !== 24'hA1B2C3) begin
            errors++;
            $display("FAIL poll2_capture: got %h%h%h want a1b2c3", sample_x, sample_y, sample_z);
        end
    endtask

    task automatic test_spurious();
        int n;
        bit ch;
        measure_cs_high(0, 1'b1, n, ch);
        checks++;
        if (n !== CS_GAP + POLL_DIV) begin
            errors++;
            $display("FAIL spurious_gap_len: got %0d want %0d", n, CS_GAP + POLL_DIV);
        end
        checks++;
        if (ch !== 1'b0) begin
            errors++;
            $display("FAIL spurious_byte_out: got changed=%b want 0", ch);
        end
        checks++;
        if ({sample_x, sample_y, sample_z} !== 24'hA1B2C3) begin
            errors++;
            $display("FAIL spurious_samples: got %h%h%h want a1b2c3", sample_x, sample_y, sample_z);
        end
    endtask

    task automatic test_enable_drop();
        serve_bytes(0, 2, POLL_B, RSP2, "poll3");
        enable = 1'b0;
        serve_bytes(3, 4, POLL_B, RSP2, "poll3");
        checks++;
        if (cs !== 1'b1 || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_cs_rise: got cs=%b bv=%b want cs=1 bv=0", cs, byte_valid);
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL drop_init_done: got %b want 0", init_done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (cs !== 1'b1 || byte_valid !== 1'b0 || {sample_x, sample_y, sample_z} !== 24'hA1B2C3) begin
            errors++;
            $display("FAIL drop_idle_hold: got cs=%b bv=%b s=%h%h%h want cs=1 bv=0 s=a1b2c3",
                     cs, byte_valid, sample_x, sample_y, sample_z);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (cs !== 1'b0 || byte_valid !== 1'b1) begin
            errors++;
            $display("FAIL reenable_latency: got cs=%b bv=%b want cs=0 bv=1", cs, byte_valid);
        end
        serve_start("reen");
    endtask

    task automatic test_rst_mid_t1();
        int n;
        bit ch;
        measure_cs_high(0, 1'b0, n, ch);
        checks++;
        if (n !== CS_GAP + RESET_WAIT) begin
            errors++;
            $display("FAIL reen_rst_wait: got %0d want %0d", n, CS_GAP + RESET_WAIT);
        end
        serve_bytes(0, 0, T1_B, RSP0, "mid_t1");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (cs !== 1'b1 || byte_valid !== 1'b0 || byte_out !== 8'h00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got cs=%b bv=%b bo=%h id=%b want cs=1 bv=0 bo=00 id=0",
                     cs, byte_valid, byte_out, init_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cs !== 1'b0 || byte_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_rst: got cs=%b bv=%b want cs=0 bv=1", cs, byte_valid);
        end
        serve_start("rst");
    endtask

`ifdef ACCEL_ID_CHECK_EN
    task automatic test_id_check();
        bit saw_valid;
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        serve_bytes(0, 2, ID_B, ID_BAD, "id_bad");
        checks++;
        if (id_err !== 1'b1 || cs !== 1'b1) begin
            errors++;
            $display("FAIL id_mismatch: got id_err=%b cs=%b want 1 1", id_err, cs);
        end
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (byte_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_parked: got byte_valid seen=%b want 0", saw_valid);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (id_err !== 1'b0) begin
            errors++;
            $display("FAIL id_err_clear: got %b want 0", id_err);
        end
        enable = 1'b1;
        serve_start("id_retry");
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_poll();
        test_spurious();
        test_enable_drop();
        test_rst_mid_t1();
`ifdef ACCEL_ID_CHECK_EN
        test_id_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
